// File: rtl/muon_burst_buffer_writer.sv
// Muon burst buffer writer: on a masked trigger, writes one header word plus
// BURST_LEN delayed ADC sample words into a ring of NBUF DPRAM buffers.
// Full buffers are handed to the CPU and returned through a release handshake.
module muon_burst_buffer_writer #(
  parameter int NCHAN     = 4,
  parameter int ADC_WIDTH = 12,
  parameter int NTRIG     = 8,
  parameter int NBUF      = 4,
  parameter int BUF_WORDS = 2048,
  parameter int BURST_LEN = 20,
  parameter int PIPE_DLY  = 4,
  localparam int DW = 16*NCHAN,
  localparam int BW = $clog2(NBUF),
  localparam int OW = $clog2(BUF_WORDS)
) (
  input  logic                       CLK120,
  input  logic                       RESET_N,
  input  logic [NCHAN*ADC_WIDTH-1:0] ADC_IN,
  input  logic [NTRIG-1:0]           TRIG_IN,
  input  logic [NTRIG-1:0]           TRIG_MASK,
  input  logic                       ENABLE,
  input  logic                       FLUSH,
  input  logic                       RELEASE,
  input  logic [BW-1:0]              RELEASE_NUM,
  output logic                       MEM_WE,
  output logic [BW+OW-1:0]           MEM_ADDR,
  output logic [DW-1:0]              MEM_DATA,
  output logic [BW-1:0]              BUF_WNUM,
  output logic [BW-1:0]              BUF_RNUM,
  output logic [NBUF-1:0]            BUF_FULL,
  output logic [BW:0]                NUM_FULL,
  output logic                       INTR,
  output logic                       BUF_DONE,
  output logic [OW:0]                RD_WORD_COUNT,
  output logic [31:0]                RD_TAG_START,
  output logic [31:0]                RD_TAG_END,
  output logic [15:0]                DROP_COUNT
);
  localparam int AW = NCHAN*ADC_WIDTH;
  localparam int HW = (DW > 64) ? DW : 64;
  localparam int KW = 15 - ADC_WIDTH;
  localparam logic [BW:0]   NBUF_V = (BW+1)'(NBUF);
  // Offset after which another full burst no longer fits in the buffer
  localparam logic [OW:0]   LIM    = (OW+1)'(BUF_WORDS - BURST_LEN - 1);
  localparam logic [OW-1:0] LAST   = OW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BURST, S_CLOSE} state_t;

  state_t                   state_q, state_d;
  logic [30:0]              tag_q;
  // PIPE_DLY pre-trigger stages plus one capture stage aligned to the write cycle
  logic [PIPE_DLY:0][AW-1:0] pipe_q;
  logic [30:0]              htag_q, htag_d;
  logic [NTRIG-1:0]         htrig_q, htrig_d;
  logic [BW-1:0]            wnum_q, wnum_d, rnum_q, rnum_d;
  logic [OW:0]              off_q, off_d;
  logic [OW-1:0]            cnt_q, cnt_d;
  logic [NBUF-1:0]          full_q, full_d;
  logic [BW:0]              nfull_q, nfull_d;
  logic [15:0]              drop_q, drop_d;
  logic                     pend_q, pend_d;
  logic [OW:0]              wc_q [NBUF];
  logic [31:0]              ts_q [NBUF];
  logic [31:0]              te_q [NBUF];
  logic [OW:0]              rd_wc_q;
  logic [31:0]              rd_ts_q, rd_te_q;

  logic [NTRIG-1:0] trig_v;
  logic             hit, flush_req, rel_ok, do_close, latch_start;
  logic [HW-1:0]    hdr;
  logic [DW-1:0]    burst_word;
  logic [KW-1:0]    kb;

  assign trig_v    = TRIG_IN & TRIG_MASK;
  assign hit       = (|trig_v) && ENABLE;
  assign flush_req = FLUSH | pend_q;
  assign rel_ok    = RELEASE && (RELEASE_NUM == rnum_q) && full_q[rnum_q];
  assign kb        = KW'(cnt_q);

  // Sample word: one 16-bit slot per channel carrying the sample index and ADC value
  for (genvar c = 0; c < NCHAN; c++) begin : g_slot
    assign burst_word[c*16 +: 16] = {1'b0, kb, pipe_q[PIPE_DLY][c*ADC_WIDTH +: ADC_WIDTH]};
  end

  // Header word: time tag of the trigger cycle and the masked trigger pattern
  always_comb begin
    hdr               = '0;
    hdr[31:0]         = {1'b1, htag_q};
    hdr[63]           = 1'b1;
    hdr[32 +: NTRIG]  = htrig_q;
  end

  // Write port driven straight from registered state so reset clears it at once
  always_comb begin
    MEM_DATA = '0;
    case (state_q)
      S_HDR:   MEM_DATA = hdr[DW-1:0];
      S_BURST: MEM_DATA = burst_word;
      default: MEM_DATA = '0;
    endcase
  end

  assign MEM_WE        = (state_q == S_HDR) || (state_q == S_BURST);
  assign MEM_ADDR      = {wnum_q, off_q[OW-1:0]};
  assign BUF_WNUM      = wnum_q;
  assign BUF_RNUM      = rnum_q;
  assign BUF_FULL      = full_q;
  assign NUM_FULL      = nfull_q;
  assign INTR          = (nfull_q != '0);
  assign BUF_DONE      = (state_q == S_CLOSE);
  assign RD_WORD_COUNT = rd_wc_q;
  assign RD_TAG_START  = rd_ts_q;
  assign RD_TAG_END    = rd_te_q;
  assign DROP_COUNT    = drop_q;

  // Next-state: burst sequencing, flush latching, drop counting and buffer bookkeeping
  always_comb begin
    state_d     = state_q;
    htag_d      = htag_q;
    htrig_d     = htrig_q;
    wnum_d      = wnum_q;
    rnum_d      = rnum_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    nfull_d     = nfull_q;
    drop_d      = drop_q;
    pend_d      = flush_req;
    do_close    = 1'b0;
    latch_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit && nfull_q != NBUF_V) begin
          state_d     = S_HDR;
          htag_d      = tag_q;
          htrig_d     = trig_v;
          latch_start = (off_q == '0);
        end else begin
          if (hit && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          // A flush on an empty buffer is simply dropped
          if (flush_req) begin
            pend_d = 1'b0;
            if (off_q != '0) state_d = S_CLOSE;
          end
        end
      end
      S_HDR: begin
        off_d   = off_q + (OW+1)'(1);
        cnt_d   = '0;
        state_d = S_BURST;
      end
      S_BURST: begin
        off_d = off_q + (OW+1)'(1);
        cnt_d = cnt_q + OW'(1);
        if (cnt_q == LAST) begin
          if (off_q >= LIM || flush_req) begin
            state_d = S_CLOSE;
            pend_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_CLOSE: begin
        do_close         = 1'b1;
        full_d[wnum_q]   = 1'b1;
        wnum_d           = wnum_q + BW'(1);
        off_d            = '0;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rel_ok) begin
      full_d[rnum_q] = 1'b0;
      rnum_d         = rnum_q + BW'(1);
    end
    if (do_close && !rel_ok)      nfull_d = nfull_q + (BW+1)'(1);
    else if (!do_close && rel_ok) nfull_d = nfull_q - (BW+1)'(1);
  end

  // Control state, time tag and ADC delay line
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      pipe_q  <= '0;
      htag_q  <= '0;
      htrig_q <= '0;
      wnum_q  <= '0;
      rnum_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      full_q  <= '0;
      nfull_q <= '0;
      drop_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_q + 31'd1;
      pipe_q  <= {pipe_q[PIPE_DLY-1:0], ADC_IN};
      htag_q  <= htag_d;
      htrig_q <= htrig_d;
      wnum_q  <= wnum_d;
      rnum_q  <= rnum_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      nfull_q <= nfull_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
    end
  end

  // Per-buffer descriptors and the registered read-side view of buffer RNUM
  always_ff @(posedge CLK120 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NBUF; i++) begin
        wc_q[i] <= '0;
        ts_q[i] <= '0;
        te_q[i] <= '0;
      end
      rd_wc_q <= '0;
      rd_ts_q <= '0;
      rd_te_q <= '0;
    end else begin
      if (latch_start) ts_q[wnum_q] <= {1'b0, tag_q};
      if (do_close) begin
        wc_q[wnum_q] <= off_q;
        te_q[wnum_q] <= {1'b0, tag_q};
      end
      rd_wc_q <= wc_q[rnum_q];
      rd_ts_q <= ts_q[rnum_q];
      rd_te_q <= te_q[rnum_q];
    end
  end
endmodule

// File: tb/tb_muon_burst_buffer_writer.sv
// Scoreboard bench for muon_burst_buffer_writer (BUF_WORDS=64, BURST_LEN=20, NBUF=4).
module tb_muon_burst_buffer_writer;
  logic        CLK120 = 1'b0;
  logic        RESET_N;
  logic [47:0] ADC_IN;
  logic [7:0]  TRIG_IN, TRIG_MASK;
  logic        ENABLE, FLUSH, RELEASE;
  logic [1:0]  RELEASE_NUM;
  logic        MEM_WE;
  logic [7:0]  MEM_ADDR;
  logic [63:0] MEM_DATA;
  logic [1:0]  BUF_WNUM, BUF_RNUM;
  logic [3:0]  BUF_FULL;
  logic [2:0]  NUM_FULL;
  logic        INTR, BUF_DONE;
  logic [6:0]  RD_WORD_COUNT;
  logic [31:0] RD_TAG_START, RD_TAG_END;
  logic [15:0] DROP_COUNT;

  muon_burst_buffer_writer #(
    .NCHAN(4), .ADC_WIDTH(12), .NTRIG(8), .NBUF(4),
    .BUF_WORDS(64), .BURST_LEN(20), .PIPE_DLY(4)
  ) dut (
    .CLK120(CLK120), .RESET_N(RESET_N), .ADC_IN(ADC_IN), .TRIG_IN(TRIG_IN),
    .TRIG_MASK(TRIG_MASK), .ENABLE(ENABLE), .FLUSH(FLUSH), .RELEASE(RELEASE),
    .RELEASE_NUM(RELEASE_NUM), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA(MEM_DATA), .BUF_WNUM(BUF_WNUM), .BUF_RNUM(BUF_RNUM),
    .BUF_FULL(BUF_FULL), .NUM_FULL(NUM_FULL), .INTR(INTR), .BUF_DONE(BUF_DONE),
    .RD_WORD_COUNT(RD_WORD_COUNT), .RD_TAG_START(RD_TAG_START),
    .RD_TAG_END(RD_TAG_END), .DROP_COUNT(DROP_COUNT)
  );

  always #5 CLK120 = ~CLK120;

  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, rel_cyc = 0, done_cnt = 0;
  int  m_wnum = 0, m_off = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] adc_of(input int n, input int c);
    return 12'(n*7 + c*1000 + 3);
  endfunction

  function automatic logic [63:0] dword(input int k, input int n);
    logic [63:0] w;
    logic [2:0]  kb;
    kb = 3'(k);
    for (int c = 0; c < 4; c++) w[c*16 +: 16] = {1'b0, kb, adc_of(n, c)};
    return w;
  endfunction

  task automatic drive_adc();
    for (int c = 0; c < 4; c++) ADC_IN[c*12 +: 12] = adc_of(cyc, c);
  endtask

  task automatic tick();
    @(posedge CLK120);
    #1;
    cyc++;
    drive_adc();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic model_close();
    m_wnum = (m_wnum + 1) % 4;
    m_off  = 0;
  endtask

  // Expected writes for a burst triggered in cycle t
  task automatic push_burst(input logic [7:0] trig, input int t);
    wr_t e;
    logic [30:0] tg;
    tg = 31'(t - rel_cyc);
    e.addr = 8'(m_wnum*64 + m_off);
    e.data = {1'b1, 23'd0, trig, 1'b1, tg};
    exp_q.push_back(e);
    for (int k = 0; k < 20; k++) begin
      e.addr = 8'(m_wnum*64 + m_off + 1 + k);
      e.data = dword(k, t - 3 + k);
      exp_q.push_back(e);
    end
    m_off += 21;
    if (m_off + 21 > 64) model_close();
  endtask

  task automatic fire(input logic [7:0] trig, input logic [7:0] mask, input bit accept, output int t);
    t = cyc;
    TRIG_IN = trig;
    TRIG_MASK = mask;
    if (accept) push_burst(trig & mask, t);
    tick();
    TRIG_IN = 8'h00;
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  // Monitor: every DUT write is matched against the scoreboard; also counts close pulses
  always @(negedge CLK120) begin
    wr_t e;
    if (RESET_N === 1'b1) begin
      if (BUF_DONE === 1'b1) done_cnt++;
      if (MEM_WE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, none required (cycle %0d)", MEM_ADDR, MEM_DATA, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 64'(MEM_ADDR), 64'(e.addr));
          chk("wr_data", MEM_DATA, e.data);
        end
      end
    end
  end

  initial begin
    int t, t1, t3;
    RESET_N = 1'b1; TRIG_IN = '0; TRIG_MASK = 8'hFF; ENABLE = 1'b1;
    FLUSH = 1'b0; RELEASE = 1'b0; RELEASE_NUM = '0;
    drive_adc();
    #2 RESET_N = 1'b0;
    repeat (3) tick();
    chk("rst_we", 64'(MEM_WE), 0);
    chk("rst_num_full", 64'(NUM_FULL), 0);
    chk("rst_wnum", 64'(BUF_WNUM), 0);
    chk("rst_drop", 64'(DROP_COUNT), 0);
    chk("rst_intr", 64'(INTR), 0);
    chk("rst_full", 64'(BUF_FULL), 0);
    RESET_N = 1'b1;
    rel_cyc = cyc;
    repeat (10) tick();

    // three bursts fill buffer 0 (offsets 0, 21, 42) and close it at 63 words
    fire(8'h01, 8'hFF, 1, t1); wait_until(t1 + 26);
    chk("b1_num_full", 64'(NUM_FULL), 0);
    fire(8'hF6, 8'h0F, 1, t); wait_until(t + 26);
    ENABLE = 1'b0; fire(8'h01, 8'hFF, 0, t); ENABLE = 1'b1; repeat (5) tick();
    fire(8'h80, 8'hFF, 1, t3); wait_until(t3 + 26);
    chk("c1_done", 64'(done_cnt), 1);
    chk("c1_wc", 64'(RD_WORD_COUNT), 63);
    chk("c1_wnum", 64'(BUF_WNUM), 1);
    chk("c1_num_full", 64'(NUM_FULL), 1);
    chk("c1_intr", 64'(INTR), 1);
    chk("c1_full", 64'(BUF_FULL), 4'b0001);
    chk("c1_tag_start", 64'(RD_TAG_START), 64'(t1 - rel_cyc));
    chk("c1_tag_end", 64'(RD_TAG_END), 64'(t3 + 22 - rel_cyc));

    // flush mid-burst closes buffer 1 right after its last word
    fire(8'h02, 8'hFF, 1, t); wait_until(t + 5); pulse_flush(); wait_until(t + 26); model_close();
    chk("f1_done", 64'(done_cnt), 2);
    chk("f1_wnum", 64'(BUF_WNUM), 2);
    chk("f1_num_full", 64'(NUM_FULL), 2);
    chk("f1_full", 64'(BUF_FULL), 4'b0011);
    chk("f1_wc_rnum0", 64'(RD_WORD_COUNT), 63);

    // release of the wrong buffer is ignored
    RELEASE = 1'b1; RELEASE_NUM = 2'd2; tick(); RELEASE = 1'b0; tick();
    chk("badrel_num_full", 64'(NUM_FULL), 2);
    chk("badrel_rnum", 64'(BUF_RNUM), 0);

    // flush in IDLE closes a part-filled buffer 2
    fire(8'h04, 8'hFF, 1, t); wait_until(t + 26); pulse_flush(); repeat (4) tick(); model_close();
    chk("f2_done", 64'(done_cnt), 3);
    chk("f2_wnum", 64'(BUF_WNUM), 3);
    chk("f2_num_full", 64'(NUM_FULL), 3);

    // flush of an empty buffer is discarded
    pulse_flush(); repeat (4) tick();
    chk("fe_done", 64'(done_cnt), 3);
    chk("fe_num_full", 64'(NUM_FULL), 3);

    // release of buffer 0 in the same cycle as the close of buffer 3
    fire(8'h08, 8'hFF, 1, t); wait_until(t + 5); pulse_flush();
    wait_until(t + 22); RELEASE = 1'b1; RELEASE_NUM = 2'd0; tick(); RELEASE = 1'b0;
    model_close(); wait_until(t + 26);
    chk("rc_done", 64'(done_cnt), 4);
    chk("rc_num_full", 64'(NUM_FULL), 3);
    chk("rc_full", 64'(BUF_FULL), 4'b1110);
    chk("rc_rnum", 64'(BUF_RNUM), 1);
    chk("rc_wnum", 64'(BUF_WNUM), 0);
    chk("rc_wc_rnum1", 64'(RD_WORD_COUNT), 21);

    // fill buffer 0 again: all four full, further triggers are dropped
    fire(8'h10, 8'hFF, 1, t); wait_until(t + 5); pulse_flush(); wait_until(t + 26); model_close();
    chk("all_num_full", 64'(NUM_FULL), 4);
    chk("all_full", 64'(BUF_FULL), 4'b1111);
    fire(8'h10, 8'h01, 0, t); tick();
    ENABLE = 1'b0; fire(8'h10, 8'hFF, 0, t); ENABLE = 1'b1; tick();
    repeat (3) begin fire(8'h20, 8'hFF, 0, t); repeat (2) tick(); end
    chk("drop_count", 64'(DROP_COUNT), 3);
    chk("drop_num_full", 64'(NUM_FULL), 4);

    RELEASE = 1'b1; RELEASE_NUM = 2'd1; tick(); RELEASE = 1'b0; tick();
    chk("rel_num_full", 64'(NUM_FULL), 3);
    chk("rel_rnum", 64'(BUF_RNUM), 2);
    chk("rel_full", 64'(BUF_FULL), 4'b1101);
    chk("rel_wc_rnum2", 64'(RD_WORD_COUNT), 21);

    // reset in the middle of a burst clears everything at once
    fire(8'h40, 8'hFF, 1, t); wait_until(t + 8);
    RESET_N = 1'b0; exp_q.delete(); m_wnum = 0; m_off = 0;
    #1;
    chk("mr_we", 64'(MEM_WE), 0);
    chk("mr_num_full", 64'(NUM_FULL), 0);
    chk("mr_wnum", 64'(BUF_WNUM), 0);
    chk("mr_rnum", 64'(BUF_RNUM), 0);
    chk("mr_drop", 64'(DROP_COUNT), 0);
    chk("mr_full", 64'(BUF_FULL), 0);
    chk("mr_wc", 64'(RD_WORD_COUNT), 0);
    chk("mr_done", 64'(BUF_DONE), 0);
    repeat (3) tick();
    RESET_N = 1'b1;
    rel_cyc = cyc;
    repeat (10) tick();
    fire(8'h01, 8'hFF, 1, t); wait_until(t + 26);
    chk("post_num_full", 64'(NUM_FULL), 0);
    chk("post_wnum", 64'(BUF_WNUM), 0);

    chk("sb_drained", 64'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
